// File: rtl/async_tx_fifo.sv
// UART transmitter with a character FIFO in front of a start/data/(parity)/stop serializer.
// Optional parity bit is compiled in with `define ASYNC_TX_PARITY_EN.
module async_tx_fifo #(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD       = 115200,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 2,
  parameter int FIFO_DEPTH = 16,
  parameter int PARITY     = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          tx_valid,
  input  logic [DATA_BITS-1:0]          tx_data,
  output logic                          tx_ready,
  output logic                          TxD,
  output logic                          TxD_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          frame_done
);

  localparam int DIV = (CLK_FREQ + BAUD / 2) / BAUD;
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = $clog2(DIV);
  localparam int BW  = $clog2(DATA_BITS);
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(FIFO_DEPTH);

  if (DIV < 2 || DATA_BITS < 5 || DATA_BITS > 9 || STOP_BITS < 1 || STOP_BITS > 2 ||
      FIFO_DEPTH < 2 || FIFO_DEPTH > 256 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
      PARITY < 0 || PARITY > 1) begin : g_param_check
    $error("async_tx_fifo: illegal parameter combination");
  end

`ifdef ASYNC_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  // ---------------------------------------------------------------- FIFO
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [AW:0]          count;
  logic                 push;
  logic                 pop;
  logic                 fifo_empty;
  logic [DATA_BITS-1:0] head;

  assign tx_ready   = (count != FULL_COUNT);
  assign push       = tx_valid && tx_ready;
  assign fifo_empty = (count == '0);
  assign head       = mem[rd_ptr];
  assign fifo_count = count;

  // NOTE: storage array has no reset; the pointers define which entries are valid.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      mem[wr_ptr] <= tx_data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // ---------------------------------------------------------------- serializer
  state_t               state;
  state_t               state_next;
  logic [CW-1:0]        cnt;
  logic [BW-1:0]        bit_idx;
  logic [BW-1:0]        idx_next;
  logic                 stop_idx;
  logic [DATA_BITS-1:0] data_reg;
  logic                 line_next;
  logic                 bit_end;
  logic                 last_data;
  logic                 last_stop;

  assign bit_end   = (cnt == '0);
  assign last_data = (bit_idx == BW'(DATA_BITS - 1));
  assign last_stop = (STOP_BITS == 1) || stop_idx;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          state_next = START;
          pop        = 1'b1;
        end
      end
      START: if (bit_end) state_next = DATA;
`ifdef ASYNC_TX_PARITY_EN
      DATA:  if (bit_end && last_data) state_next = PAR;
      PAR:   if (bit_end) state_next = STOP;
`else
      DATA:  if (bit_end && last_data) state_next = STOP;
`endif
      STOP: begin
        // The last stop cycle chains straight into the next start bit when data is waiting.
        if (bit_end && last_stop) begin
          if (!fifo_empty) begin
            state_next = START;
            pop        = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // TxD is registered, so its next value is derived from the next state.
  always_comb begin
    TxD_busy   = (state != IDLE);
    frame_done = (state == STOP) && bit_end && last_stop;
    idx_next   = (state == DATA && bit_end) ? bit_idx + 1'b1 : bit_idx;
    case (state_next)
      START:   line_next = 1'b0;
      DATA:    line_next = data_reg[idx_next];
`ifdef ASYNC_TX_PARITY_EN
      PAR:     line_next = (^data_reg) ^ 1'(PARITY);
`endif
      default: line_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      TxD      <= 1'b1;
      cnt      <= '0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      data_reg <= '0;
    end else begin
      TxD <= line_next;
      if (state_next != state || bit_end) cnt <= CW'(DIV - 1);
      else                                cnt <= cnt - 1'b1;
      if (state == DATA && bit_end) bit_idx <= last_data ? '0 : bit_idx + 1'b1;
      if (state == STOP && bit_end) stop_idx <= 1'b1;
      if (pop) begin
        data_reg <= head;
        bit_idx  <= '0;
        stop_idx <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_async_tx_fifo.sv
// Scoreboard bench for async_tx_fifo: DIV=10, FIFO_DEPTH=4, two stop bits.
// With ASYNC_TX_PARITY_EN defined it runs 7 data bits with odd parity.
module tb_async_tx_fifo;

`ifdef ASYNC_TX_PARITY_EN
  localparam int DB       = 7;
  localparam int PAR_BITS = 1;
  localparam int PAR_VAL  = 1;
  localparam logic [31:0] HAND_LINE = 32'h706;
`else
  localparam int DB       = 8;
  localparam int PAR_BITS = 0;
  localparam int PAR_VAL  = 0;
  localparam logic [31:0] HAND_LINE = 32'h6AA;
`endif
  localparam int DIV        = 10;
  localparam int NBITS      = 1 + DB + PAR_BITS + 2;
  localparam int FRAME_CLKS = 110;

  typedef logic [DB-1:0] ch_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          tx_valid = 1'b0;
  ch_t           tx_data = '0;
  logic          tx_ready;
  logic          TxD;
  logic          TxD_busy;
  logic [2:0]    fifo_count;
  logic          frame_done;

  int tests  = 0;
  int failed = 0;
  int cycle_no = 0;
  ch_t exp_q[$];
  int  starts[$];
  int  dones[$];

  async_tx_fifo #(
    .CLK_FREQ(1000), .BAUD(100), .DATA_BITS(DB), .STOP_BITS(2),
    .FIFO_DEPTH(4), .PARITY(PAR_VAL)
  ) dut (
    .clk(clk), .rst(rst), .tx_valid(tx_valid), .tx_data(tx_data),
    .tx_ready(tx_ready), .TxD(TxD), .TxD_busy(TxD_busy),
    .fifo_count(fifo_count), .frame_done(frame_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle_no <= cycle_no + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      failed++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, got, want);
    end
  endtask

  // Line model: start 0, data LSB first, optional parity, two stop bits.
  function automatic logic [31:0] frame_model(input ch_t c);
    logic [31:0] l;
    int idx;
    l = '0;
    for (int i = 0; i < DB; i++) l[1 + i] = c[i];
    idx = 1 + DB;
`ifdef ASYNC_TX_PARITY_EN
    l[idx] = (^c) ^ 1'b1;
    idx++;
`endif
    l[idx]     = 1'b1;
    l[idx + 1] = 1'b1;
    return l;
  endfunction

  // Monitor: decodes every frame on TxD and compares against the scoreboard queue.
  initial begin
    bit          in_frame;
    bit          have;
    int          cyc;
    int          unstable;
    logic        samp [FRAME_CLKS];
    logic [31:0] got;
    ch_t         cur;
    in_frame = 0;
    have     = 0;
    cyc      = 0;
    cur      = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        in_frame = 0;
      end else if (!in_frame) begin
        if (frame_done) check("frame_done_idle", {31'b0, frame_done}, 0);
        if (TxD === 1'b0) begin
          in_frame = 1;
          cyc      = 0;
          samp[0]  = TxD;
          starts.push_back(cycle_no);
          have = (exp_q.size() != 0);
          check("frame_expected", {31'b0, have}, 1);
          if (have) cur = exp_q.pop_front();
        end
      end else begin
        cyc++;
        samp[cyc] = TxD;
        if (cyc == FRAME_CLKS - 1) begin
          check("frame_done_at_end", {31'b0, frame_done}, 1);
          if (frame_done) dones.push_back(cycle_no);
          got = '0;
          unstable = 0;
          for (int b = 0; b < NBITS; b++) begin
            got[b] = samp[b * DIV + DIV / 2];
            for (int k = 0; k < DIV; k++)
              if (samp[b * DIV + k] !== got[b]) unstable++;
          end
          check("bit_stable", unstable, 0);
          if (have) check("frame_line", got, frame_model(cur));
          in_frame = 0;
        end else if (frame_done) begin
          check("frame_done_early", {31'b0, frame_done}, 0);
        end
      end
    end
  end

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    @(negedge clk);
    while ((TxD_busy || fifo_count != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("idle_reached", {31'b0, n < budget}, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  initial begin
    ch_t         first;
    ch_t         xs [6];
    ch_t         y;
    logic [31:0] line;
    int          done_at;
    int          n0;
    int          d0;
    int          pre_cnt;
    int          lows;
    bit          acc;
    bit          r;
    bit          found;

`ifdef ASYNC_TX_PARITY_EN
    first = 7'h03;
`else
    first = 8'h55;
`endif
    xs = '{ch_t'(8'h21), ch_t'(8'h32), ch_t'(8'h43), ch_t'(8'h54), ch_t'(8'h65), ch_t'(8'h76)};
    y  = ch_t'(8'h0E);

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_txd", {31'b0, TxD}, 1);
    check("rst_busy", {31'b0, TxD_busy}, 0);
    check("rst_ready", {31'b0, tx_ready}, 1);
    check("rst_count", {29'b0, fifo_count}, 0);
    check("rst_frame_done", {31'b0, frame_done}, 0);

    // Single character: 2 clocks from write edge to start bit, hand-computed line.
    @(posedge clk); #1;
    tx_valid = 1'b1; tx_data = first; exp_q.push_back(first);
    @(posedge clk); #1;
    tx_valid = 1'b0;
    @(negedge clk);
    check("wr_edge_txd", {31'b0, TxD}, 1);
    check("wr_edge_count", {29'b0, fifo_count}, 1);
    @(negedge clk);
    check("start_txd", {31'b0, TxD}, 0);
    check("start_busy", {31'b0, TxD_busy}, 1);
    check("pop_count", {29'b0, fifo_count}, 0);
    line = '0;
    done_at = -1;
    for (int c = 1; c < FRAME_CLKS; c++) begin
      @(negedge clk);
      if (c % DIV == DIV / 2) line[c / DIV] = TxD;
      if (frame_done && done_at < 0) done_at = c;
    end
    check("hand_line", line, HAND_LINE);
    check("frame_done_clk", done_at, 109);
    wait_idle(50);

    // Back-to-back: second write coincides with the first pop.
    n0 = starts.size();
    d0 = dones.size();
    @(posedge clk); #1;
    tx_valid = 1'b1; tx_data = '0; exp_q.push_back('0);
    @(posedge clk); #1;
    tx_data = '1; exp_q.push_back('1);
    @(posedge clk); #1;
    tx_valid = 1'b0;
    @(negedge clk);
    check("push_pop_count", {29'b0, fifo_count}, 1);
    wait_idle(400);
    check("b2b_frames", starts.size() - n0, 2);
    check("b2b_start_gap", starts[n0 + 1] - starts[n0], 110);
    check("b2b_done_gap", dones[d0 + 1] - dones[d0], 110);

    // Full FIFO while the line is busy: writes 5 and 6 are dropped.
    @(posedge clk); #1;
    tx_valid = 1'b1; tx_data = ch_t'(8'h11); exp_q.push_back(ch_t'(8'h11));
    @(posedge clk); #1;
    tx_valid = 1'b0;
    repeat (3) @(posedge clk);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (i == 4) begin
        check("full_ready", {31'b0, tx_ready}, 0);
        check("full_count", {29'b0, fifo_count}, 4);
      end
      tx_valid = 1'b1; tx_data = xs[i];
      if (i < 4) exp_q.push_back(xs[i]);
    end
    @(posedge clk); #1;
    tx_valid = 1'b0;
    @(negedge clk);
    check("dropped_count", {29'b0, fifo_count}, 4);

    // Held write at full: the pop frees a slot for the following edge only.
    @(posedge clk); #1;
    tx_valid = 1'b1; tx_data = y; exp_q.push_back(y);
    acc = 0;
    pre_cnt = -1;
    for (int k = 0; k < 300 && !acc; k++) begin
      @(negedge clk);
      pre_cnt = fifo_count;
      r = tx_ready;
      @(posedge clk);
      if (r) acc = 1;
    end
    #1 tx_valid = 1'b0;
    check("refill_accepted", {31'b0, acc}, 1);
    check("slot_freed_count", pre_cnt, 3);
    @(negedge clk);
    check("refill_count", {29'b0, fifo_count}, 4);
    wait_idle(1000);

    // Reset during data bit 3 with one character still queued.
    @(posedge clk); #1;
    tx_valid = 1'b1; tx_data = ch_t'(8'h55); exp_q.push_back(ch_t'(8'h55));
    @(posedge clk); #1;
    tx_data = ch_t'(8'h33); exp_q.push_back(ch_t'(8'h33));
    @(posedge clk); #1;
    tx_valid = 1'b0;
    found = 0;
    for (int k = 0; k < 10 && !found; k++) begin
      @(negedge clk);
      if (TxD === 1'b0) found = 1;
    end
    check("rst_test_started", {31'b0, found}, 1);
    repeat (42) @(negedge clk);
    check("pre_reset_count", {29'b0, fifo_count}, 1);
    @(posedge clk); #1;
    rst = 1'b1; tx_valid = 1'b1; tx_data = ch_t'(8'h0F);
    exp_q.delete();
    d0 = dones.size();
    @(posedge clk); #1;
    rst = 1'b0; tx_valid = 1'b0;
    @(negedge clk);
    check("mid_rst_txd", {31'b0, TxD}, 1);
    check("mid_rst_count", {29'b0, fifo_count}, 0);
    check("mid_rst_busy", {31'b0, TxD_busy}, 0);
    check("mid_rst_ready", {31'b0, tx_ready}, 1);
    check("mid_rst_frame_done", {31'b0, frame_done}, 0);
    lows = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (TxD !== 1'b1) lows++;
    end
    check("quiet_line", lows, 0);
    check("no_done_after_reset", dones.size() - d0, 0);

    // A clean frame after reset.
    @(posedge clk); #1;
    tx_valid = 1'b1; tx_data = ch_t'(8'h5A); exp_q.push_back(ch_t'(8'h5A));
    @(posedge clk); #1;
    tx_valid = 1'b0;
    wait_idle(300);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
